usb_ulpi_top: RTL and testbench



---
 rtl/usb_ulpi_pkg.sv | 51 +++++
 rtl/usb_ulpi_ctrl.sv | 206 ++++++++++++++++++++
 rtl/usb_ulpi_top.sv | 108 ++++++++++
 tb/tb_usb_ulpi_top.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/usb_ulpi_pkg.sv
// usb_ulpi_pkg: shared definitions for the ULPI link bring-up path.
// Contents: link FSM state encoding, ULPI command constants, RX CMD field
// positions and small helpers to build TX commands and split RX CMD bytes.
package usb_ulpi_pkg;

    // Link bring-up sequence: PHY reset, wait for bus, one register write, run.
    typedef enum logic [2:0] {
        ST_PHY_RST  = 3'd0,
        ST_PHY_WAIT = 3'd1,
        ST_WR_CMD   = 3'd2,
        ST_WR_DATA  = 3'd3,
        ST_WR_STP   = 3'd4,
        ST_RUN      = 3'd5
    } ulpi_state_e;

    // TX command byte = {command code, register address}.
    localparam logic [1:0] REG_WRITE      = 2'b10;
    localparam logic [5:0] FUNC_CTRL_ADDR = 6'h04;

    // Byte the link drives while it owns the bus with nothing to send.
    localparam logic [7:0] ULPI_IDLE = 8'h00;

    // RX CMD field positions (each field is two bits wide).
    localparam int LINESTATE_LSB = 0;
    localparam int VBUS_LSB      = 2;
    localparam int RXEVENT_LSB   = 4;

    // Full-speed J state on the line.
    localparam logic [1:0] LINESTATE_J = 2'b01;

    typedef struct packed {
        logic [1:0] rxevent;
        logic [1:0] vbus;
        logic [1:0] linestate;
    } rx_cmd_t;

    // Build a register-write TX command for an immediate register address.
    function automatic logic [7:0] reg_write_cmd(input logic [5:0] addr);
        return {REG_WRITE, addr};
    endfunction

    // Split an RX CMD byte into its status fields.
    function automatic rx_cmd_t decode_rx_cmd(input logic [7:0] b);
        rx_cmd_t r;
        r.linestate = b[LINESTATE_LSB +: 2];
        r.vbus      = b[VBUS_LSB +: 2];
        r.rxevent   = b[RXEVENT_LSB +: 2];
        return r;
    endfunction

endpackage

// File: rtl/usb_ulpi_ctrl.sv
// ulpi_ctrl: ULPI link engine.
// - Holds the PHY in hardware reset for PHY_RESET_CYCLES, then waits for the
//   PHY to hand the bus to the link.
// - Writes FUNC_CTRL_VAL to the Function Control register once (command,
//   data, stop), restarting the write if the PHY takes the bus mid-write.
// - Generates the registered data output enable from DIR history so every
//   DIR edge gets a one-cycle turnaround.
// - Decodes RX CMD bytes into linestate / vbus / rxevent.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   dir_i, nxt_i        ULPI DIR / NXT from the PHY
//   data_i              ULPI data bus as seen at the pad
//   data_o, data_oe_o   link data and its output enable (registered)
//   stp_o, cs_o         ULPI STP and chip select (registered)
//   resetn_o            PHY hardware reset, active-low (registered)
//   run_o               high once the register write has completed
//   rx_cmd_o            most recent RX CMD status fields
module ulpi_ctrl
    import usb_ulpi_pkg::*;
#(
    parameter int          PHY_RESET_CYCLES = 60,
    parameter logic [7:0]  FUNC_CTRL_VAL    = 8'h45
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dir_i,
    input  logic        nxt_i,
    input  logic [7:0]  data_i,
    output logic [7:0]  data_o,
    output logic        data_oe_o,
    output logic        stp_o,
    output logic        cs_o,
    output logic        resetn_o,
    output logic        run_o,
    output rx_cmd_t     rx_cmd_o
);

    localparam int CNT_W = (PHY_RESET_CYCLES > 1) ? $clog2(PHY_RESET_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHY_RESET_CYCLES - 1);

    ulpi_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             dir_q;
    logic             bus_free_s;
    logic             rx_cmd_s;

    logic [7:0]       data_q, data_d;
    logic             oe_q, oe_d;
    logic             stp_q, stp_d;
    logic             cs_q, cs_d;
    logic             resetn_q, resetn_d;
    logic             run_q, run_d;
    rx_cmd_t          rx_cmd_q;

    // The link may only own the bus after DIR has been low for two samples.
    assign bus_free_s = ~dir_i & ~dir_q;

    // A turned-around cycle with DIR high and NXT low carries an RX CMD.
    assign rx_cmd_s = dir_i & dir_q & ~nxt_i;

    // State register and PHY reset counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_PHY_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic for the bring-up sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_PHY_RST: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_PHY_WAIT;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_PHY_RST;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_PHY_WAIT: begin
                if (bus_free_s) begin
                    state_d = ST_WR_CMD;
                end else begin
                    state_d = ST_PHY_WAIT;
                end
            end
            ST_WR_CMD: begin
                // NXT only means "command accepted" while we drove this cycle.
                if (dir_i) begin
                    state_d = ST_WR_CMD;
                end else if (oe_q && nxt_i) begin
                    state_d = ST_WR_DATA;
                end else begin
                    state_d = ST_WR_CMD;
                end
            end
            ST_WR_DATA: begin
                if (dir_i) begin
                    state_d = ST_WR_CMD;
                end else begin
                    state_d = ST_WR_STP;
                end
            end
            ST_WR_STP: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_PHY_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so every output is a flop.
    always_comb begin
        data_d   = ULPI_IDLE;
        oe_d     = bus_free_s;
        stp_d    = 1'b0;
        cs_d     = 1'b1;
        resetn_d = 1'b1;
        run_d    = 1'b0;
        case (state_d)
            ST_PHY_RST: begin
                resetn_d = 1'b0;
                oe_d     = 1'b0;
            end
            ST_PHY_WAIT: begin
                data_d = ULPI_IDLE;
            end
            ST_WR_CMD: begin
                data_d = reg_write_cmd(FUNC_CTRL_ADDR);
            end
            ST_WR_DATA: begin
                data_d = FUNC_CTRL_VAL;
            end
            ST_WR_STP: begin
                stp_d = 1'b1;
            end
            ST_RUN: begin
                run_d = 1'b1;
            end
            default: begin
                resetn_d = 1'b0;
                oe_d     = 1'b0;
            end
        endcase
    end

    // Output registers; reset releases the bus and holds the PHY in reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q   <= ULPI_IDLE;
            oe_q     <= 1'b0;
            stp_q    <= 1'b0;
            cs_q     <= 1'b0;
            resetn_q <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            data_q   <= data_d;
            oe_q     <= oe_d;
            stp_q    <= stp_d;
            cs_q     <= cs_d;
            resetn_q <= resetn_d;
            run_q    <= run_d;
        end
    end

    // DIR history; assume the PHY owns the bus coming out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dir_q <= 1'b1;
        end else begin
            dir_q <= dir_i;
        end
    end

    // RX CMD capture; packet data (NXT high) leaves the status untouched.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_cmd_q <= '0;
        end else if (rx_cmd_s) begin
            rx_cmd_q <= decode_rx_cmd(data_i);
        end else begin
            rx_cmd_q <= rx_cmd_q;
        end
    end

    assign data_o    = data_q;
    assign data_oe_o = oe_q;
    assign stp_o     = stp_q;
    assign cs_o      = cs_q;
    assign resetn_o  = resetn_q;
    assign run_o     = run_q;
    assign rx_cmd_o  = rx_cmd_q;

endmodule

// File: rtl/usb_ulpi_top.sv
// usb_ulpi_top: FPGA top for the audio card USB path.
// Brings up the external ULPI PHY through ulpi_ctrl, owns the ULPI data pad
// buffer and drives the status LED:
//   - VBUS fault (USB_FAULTN low): LED blinks, toggling every 2^LED_DIV cycles
//   - otherwise, link running and line in J: LED on
//   - otherwise: LED off
// Ports:
//   CLK, RST             60 MHz ULPI clock, synchronous active-high reset
//   USB_DATA             ULPI data bus (bidirectional)
//   USB_DIR, USB_NXT     ULPI bus direction / throttle from the PHY
//   USB_STP              ULPI stop strobe
//   USB_CS, USB_RESETN   PHY chip select, PHY hardware reset (active-low)
//   USB_FAULTN           VBUS fault input, active-low
//   LED                  status indicator
module usb_ulpi_top
    import usb_ulpi_pkg::*;
#(
    parameter int          PHY_RESET_CYCLES = 60,
    parameter logic [7:0]  FUNC_CTRL_VAL    = 8'h45,
    parameter int          LED_DIV          = 23
) (
    input  logic        CLK,
    input  logic        RST,
    inout  wire  [7:0]  USB_DATA,
    input  logic        USB_DIR,
    input  logic        USB_NXT,
    output logic        USB_STP,
    output logic        USB_CS,
    output logic        USB_RESETN,
    input  logic        USB_FAULTN,
    output logic        LED
);

    logic [7:0]         data_out_s;
    logic               data_oe_s;
    logic               run_s;
    rx_cmd_t            rx_cmd_s;

    logic               faultn_meta_q;
    logic               faultn_sync_q;
    logic [LED_DIV-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_q, blink_d;
    logic               led_q, led_d;

    ulpi_ctrl #(
        .PHY_RESET_CYCLES (PHY_RESET_CYCLES),
        .FUNC_CTRL_VAL    (FUNC_CTRL_VAL)
    ) u_ulpi_ctrl (
        .clk_i     (CLK),
        .rst_i     (RST),
        .dir_i     (USB_DIR),
        .nxt_i     (USB_NXT),
        .data_i    (USB_DATA),
        .data_o    (data_out_s),
        .data_oe_o (data_oe_s),
        .stp_o     (USB_STP),
        .cs_o      (USB_CS),
        .resetn_o  (USB_RESETN),
        .run_o     (run_s),
        .rx_cmd_o  (rx_cmd_s)
    );

    assign USB_DATA = data_oe_s ? data_out_s : 8'hzz;

    // Fault input comes from off-chip asynchronously; two-flop synchroniser.
    always_ff @(posedge CLK) begin
        if (RST) begin
            faultn_meta_q <= 1'b1;
            faultn_sync_q <= 1'b1;
        end else begin
            faultn_meta_q <= USB_FAULTN;
            faultn_sync_q <= faultn_meta_q;
        end
    end

    // Blink divider and LED source selection.
    always_comb begin
        blink_cnt_d = blink_cnt_q + LED_DIV'(1);
        if (&blink_cnt_q) begin
            blink_d = ~blink_q;
        end else begin
            blink_d = blink_q;
        end
        if (!faultn_sync_q) begin
            led_d = blink_q;
        end else if (run_s && (rx_cmd_s.linestate == LINESTATE_J)) begin
            led_d = 1'b1;
        end else begin
            led_d = 1'b0;
        end
    end

    // LED registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            led_q       <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            led_q       <= led_d;
        end
    end

    assign LED = led_q;

endmodule

// File: tb/tb_usb_ulpi_top.sv
// Directed bench for usb_ulpi_top. A small PHY model drives USB_DATA from the
// cycle after DIR rises; pull-ups make a released bus read as 8'hFF.
module tb_usb_ulpi_top;

    logic       CLK;
    logic       RST;
    logic       USB_DIR;
    logic       USB_NXT;
    logic       USB_STP;
    logic       USB_CS;
    logic       USB_RESETN;
    logic       USB_FAULTN;
    logic       LED;
    wire  [7:0] usb_data;

    logic [7:0] phy_data;
    logic       phy_en;
    logic       phy_oe_r;

    int n_cmp;
    int n_bad;

    localparam logic [7:0] BUS_Z = 8'hFF;

    usb_ulpi_top #(
        .PHY_RESET_CYCLES (60),
        .FUNC_CTRL_VAL    (8'h45),
        .LED_DIV          (3)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .USB_DATA   (usb_data),
        .USB_DIR    (USB_DIR),
        .USB_NXT    (USB_NXT),
        .USB_STP    (USB_STP),
        .USB_CS     (USB_CS),
        .USB_RESETN (USB_RESETN),
        .USB_FAULTN (USB_FAULTN),
        .LED        (LED)
    );

    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (usb_data[g]);
    end

    assign usb_data = (USB_DIR && phy_oe_r && phy_en) ? phy_data : 8'hzz;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) phy_oe_r <= USB_DIR;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        RST = 1'b1; USB_DIR = 1'b0; USB_NXT = 1'b0; USB_FAULTN = 1'b1;
        phy_data = 8'h00; phy_en = 1'b1;
        tick; tick;
        n_cmp++; if (USB_RESETN !== 1'b0) begin n_bad++; $display("FAIL rst_resetn got %b want 0", USB_RESETN); end
        n_cmp++; if (USB_STP !== 1'b0) begin n_bad++; $display("FAIL rst_stp got %b want 0", USB_STP); end
        n_cmp++; if (USB_CS !== 1'b0) begin n_bad++; $display("FAIL rst_cs got %b want 0", USB_CS); end
        n_cmp++; if (LED !== 1'b0) begin n_bad++; $display("FAIL rst_led got %b want 0", LED); end
        n_cmp++; if (usb_data !== BUS_Z) begin n_bad++; $display("FAIL rst_bus got %h want released(ff)", usb_data); end
        USB_DIR = 1'b1;
        tick;
        RST = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            tick;
            n_cmp++;
            if (USB_RESETN !== (i >= 60)) begin
                n_bad++; $display("FAIL resetn_seq cycle %0d got %b want %b", i, USB_RESETN, (i >= 60));
            end
            if (i == 1) begin
                n_cmp++; if (USB_CS !== 1'b1) begin n_bad++; $display("FAIL cs_first got %b want 1", USB_CS); end
            end
        end
    endtask

    task automatic test_abort;
        USB_DIR = 1'b0;
        tick; tick;
        n_cmp++; if (usb_data !== 8'h84) begin n_bad++; $display("FAIL abort_cmd1 got %h want 84", usb_data); end
        phy_en = 1'b0; USB_DIR = 1'b1;
        tick;
        n_cmp++; if (usb_data !== BUS_Z) begin n_bad++; $display("FAIL abort_release got %h want ff", usb_data); end
        tick;
        n_cmp++; if (usb_data !== BUS_Z) begin n_bad++; $display("FAIL abort_hold got %h want ff", usb_data); end
        USB_DIR = 1'b0;
        tick;
        n_cmp++; if (usb_data !== BUS_Z) begin n_bad++; $display("FAIL abort_turn got %h want ff", usb_data); end
        tick;
        n_cmp++; if (usb_data !== 8'h84) begin n_bad++; $display("FAIL abort_redrive got %h want 84", usb_data); end
    endtask

    task automatic test_write;
        tick;
        n_cmp++; if (usb_data !== 8'h84) begin n_bad++; $display("FAIL wr_cmd2 got %h want 84", usb_data); end
        tick;
        n_cmp++; if (usb_data !== 8'h84) begin n_bad++; $display("FAIL wr_cmd3 got %h want 84", usb_data); end
        USB_NXT = 1'b1;
        tick;
        USB_NXT = 1'b0;
        n_cmp++; if (usb_data !== 8'h45) begin n_bad++; $display("FAIL wr_data got %h want 45", usb_data); end
        n_cmp++; if (USB_STP !== 1'b0) begin n_bad++; $display("FAIL wr_data_stp got %b want 0", USB_STP); end
        tick;
        n_cmp++; if (USB_STP !== 1'b1) begin n_bad++; $display("FAIL wr_stp got %b want 1", USB_STP); end
        n_cmp++; if (usb_data !== 8'h00) begin n_bad++; $display("FAIL wr_stp_data got %h want 00", usb_data); end
        tick;
        n_cmp++; if (USB_STP !== 1'b0) begin n_bad++; $display("FAIL run_stp got %b want 0", USB_STP); end
        n_cmp++; if (usb_data !== 8'h00) begin n_bad++; $display("FAIL run_idle got %h want 00", usb_data); end
        n_cmp++; if (LED !== 1'b0) begin n_bad++; $display("FAIL run_led got %b want 0", LED); end
    endtask

    task automatic test_rx_cmd;
        phy_en = 1'b1; phy_data = 8'h01; USB_DIR = 1'b1;
        tick; tick;
        n_cmp++; if (LED !== 1'b0) begin n_bad++; $display("FAIL rx_led_early got %b want 0", LED); end
        tick;
        n_cmp++; if (LED !== 1'b1) begin n_bad++; $display("FAIL rx_led_j got %b want 1", LED); end
        phy_data = 8'h00;
        tick;
        n_cmp++; if (LED !== 1'b1) begin n_bad++; $display("FAIL rx_led_lag got %b want 1", LED); end
        tick;
        n_cmp++; if (LED !== 1'b0) begin n_bad++; $display("FAIL rx_led_se0 got %b want 0", LED); end
        phy_data = 8'h01; USB_NXT = 1'b1;
        tick; tick;
        n_cmp++; if (LED !== 1'b0) begin n_bad++; $display("FAIL rx_pkt_ignored got %b want 0", LED); end
        USB_NXT = 1'b0;
        tick; tick;
        n_cmp++; if (LED !== 1'b1) begin n_bad++; $display("FAIL rx_led_j2 got %b want 1", LED); end
        USB_DIR = 1'b0;
        tick;
        n_cmp++; if (usb_data !== BUS_Z) begin n_bad++; $display("FAIL rx_turn got %h want ff", usb_data); end
        tick;
        n_cmp++; if (usb_data !== 8'h00) begin n_bad++; $display("FAIL rx_idle got %h want 00", usb_data); end
    endtask

    task automatic test_fault;
        logic v;
        logic found;
        USB_FAULTN = 1'b0;
        tick; tick; tick; tick;
        v = LED;
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            tick;
            if (LED !== v) found = 1'b1;
        end
        n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL blink_start got no toggle want toggle within 12"); end
        v = LED;
        for (int p = 0; p < 2; p++) begin
            for (int k = 1; k <= 7; k++) begin
                tick;
                n_cmp++; if (LED !== v) begin n_bad++; $display("FAIL blink_hold p%0d c%0d got %b want %b", p, k, LED, v); end
            end
            tick;
            n_cmp++; if (LED !== ~v) begin n_bad++; $display("FAIL blink_toggle p%0d got %b want %b", p, LED, ~v); end
            v = ~v;
        end
        USB_FAULTN = 1'b1;
        tick; tick; tick; tick;
        n_cmp++; if (LED !== 1'b1) begin n_bad++; $display("FAIL fault_clear got %b want 1", LED); end
    endtask

    task automatic test_mid_reset;
        RST = 1'b1; phy_en = 1'b0; USB_DIR = 1'b1;
        tick;
        RST = 1'b0;
        for (int i = 1; i <= 60; i++) tick;
        n_cmp++; if (USB_RESETN !== 1'b1) begin n_bad++; $display("FAIL mr_resetn_up got %b want 1", USB_RESETN); end
        USB_DIR = 1'b0;
        tick; tick;
        n_cmp++; if (usb_data !== 8'h84) begin n_bad++; $display("FAIL mr_cmd got %h want 84", usb_data); end
        USB_NXT = 1'b1;
        tick;
        USB_NXT = 1'b0;
        n_cmp++; if (usb_data !== 8'h45) begin n_bad++; $display("FAIL mr_data got %h want 45", usb_data); end
        RST = 1'b1;
        tick;
        RST = 1'b0;
        n_cmp++; if (usb_data !== BUS_Z) begin n_bad++; $display("FAIL mr_bus got %h want ff", usb_data); end
        n_cmp++; if (USB_STP !== 1'b0) begin n_bad++; $display("FAIL mr_stp got %b want 0", USB_STP); end
        n_cmp++; if (USB_RESETN !== 1'b0) begin n_bad++; $display("FAIL mr_resetn got %b want 0", USB_RESETN); end
        for (int i = 1; i <= 3; i++) begin
            tick;
            n_cmp++; if (USB_STP !== 1'b0) begin n_bad++; $display("FAIL mr_stp_after c%0d got %b want 0", i, USB_STP); end
            n_cmp++; if (usb_data !== BUS_Z) begin n_bad++; $display("FAIL mr_bus_after c%0d got %h want ff", i, usb_data); end
            n_cmp++; if (USB_RESETN !== 1'b0) begin n_bad++; $display("FAIL mr_phy_rst c%0d got %b want 0", i, USB_RESETN); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset;
        test_abort;
        test_write;
        test_rx_cmd;
        test_fault;
        test_mid_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
